// File: rtl/sr_comp_pkg.sv
// Shared definitions for the SR compressor scheduler.
package sr_comp_pkg;

    localparam int unsigned SR_BEATS_PER_BLK = 16;
    localparam int unsigned SR_DATA_W        = 64;
    localparam int unsigned SR_MAX_REQ       = 8;

    typedef enum logic [0:0] {IDLE, BURST} sr_sched_state_e;

    // Wide enough for the largest supported requester count
    typedef logic [$clog2(SR_MAX_REQ)-1:0] sr_req_id_t;

endpackage

// File: rtl/sr_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module sr_rr_arb #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld
);

    // Scan NUM_REQ positions starting at ptr, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_comp_sched.sv
// Block scheduler sharing one SR compressor core among NUM_REQ beat streams.
// Optional per-requester statistics: define SR_COMP_SCHED_STATS_EN.
module sr_comp_sched
    import sr_comp_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  DATA_W  = SR_DATA_W,
    parameter int unsigned  BEATS   = SR_BEATS_PER_BLK,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sched_en_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      core_valid_o,
    output logic                      core_sop_o,
    output logic                      core_eop_o,
    output logic [DATA_W-1:0]         core_data_o,
    input  logic                      core_d_valid_i,
    input  logic                      core_s_valid_i,
    input  logic                      core_size_i,
`ifdef SR_COMP_SCHED_STATS_EN
    input  logic                      stats_clr_i,
    output logic [NUM_REQ*16-1:0]     blk_cnt_o,
    output logic [NUM_REQ*16-1:0]     cmp_cnt_o,
`endif
    output logic [ID_W-1:0]           res_id_o,
    output logic                      busy_o
);

    localparam int unsigned CNT_W = $clog2(BEATS);

    sr_sched_state_e    state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [ID_W-1:0]    id1_q;
    logic [ID_W-1:0]    res_id_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_vld;
    logic               grant_take;
    logic               accept;
    logic               last_beat;
    logic [DATA_W-1:0]  sel_data;

    sr_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid_i),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .gnt_vld (arb_vld)
    );

    assign grant_take = (state_q == IDLE) && sched_en_i && arb_vld;
    assign accept     = |(req_valid_i & req_ready_o);
    assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign sel_data   = req_data_i[32'(gnt_id_q) * DATA_W +: DATA_W];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a block only ends on its last accepted beat
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_take) state_d = BURST;
            BURST:   if (accept && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only the grant holder sees ready, and only inside a block
    always_comb begin
        req_ready_o = (state_q == BURST) ? gnt_q : '0;
        busy_o      = (state_q != IDLE);
    end

    // Grant, round-robin pointer and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (grant_take) begin
                gnt_q    <= arb_gnt;
                gnt_id_q <= arb_id;
                rr_ptr_q <= (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + ID_W'(1);
            end
            if (accept) beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    // Core drive: one registered stage after the accepting cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid_o <= 1'b0;
            core_sop_o   <= 1'b0;
            core_eop_o   <= 1'b0;
            core_data_o  <= '0;
        end else begin
            core_valid_o <= accept;
            core_sop_o   <= accept && (beat_cnt_q == '0);
            core_eop_o   <= accept && last_beat;
            core_data_o  <= accept ? sel_data : '0;
        end
    end

    // Owner id follows each beat: stage 1 with the core beat, stage 2 with its result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id1_q    <= '0;
            res_id_q <= '0;
        end else begin
            if (accept)       id1_q    <= gnt_id_q;
            if (core_valid_o) res_id_q <= id1_q;
        end
    end

    assign res_id_o = res_id_q;

`ifdef SR_COMP_SCHED_STATS_EN
    logic [15:0] blk_cnt_q [NUM_REQ];
    logic [15:0] cmp_cnt_q [NUM_REQ];
    logic        unused_core_in;

    assign unused_core_in = core_d_valid_i;

    // Saturating per-requester block / compressible-block counters; clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                blk_cnt_q[r] <= '0;
                cmp_cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (stats_clr_i) begin
                    blk_cnt_q[r] <= '0;
                    cmp_cnt_q[r] <= '0;
                end else if (core_s_valid_i && (res_id_q == ID_W'(r))) begin
                    if (blk_cnt_q[r] != 16'hffff) blk_cnt_q[r] <= blk_cnt_q[r] + 16'd1;
                    if (!core_size_i && (cmp_cnt_q[r] != 16'hffff)) begin
                        cmp_cnt_q[r] <= cmp_cnt_q[r] + 16'd1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats_flat
        assign blk_cnt_o[g*16 +: 16] = blk_cnt_q[g];
        assign cmp_cnt_o[g*16 +: 16] = cmp_cnt_q[g];
    end
`else
    logic unused_core_in;

    assign unused_core_in = ^{core_d_valid_i, core_s_valid_i, core_size_i};
`endif

endmodule

// File: tb/tb_sr_comp_sched.sv
// Self-checking bench for sr_comp_sched (NUM_REQ=4, DATA_W=64, BEATS=16).
// Build with SR_COMP_SCHED_STATS_EN defined to also cover the statistics ports.
module tb_sr_comp_sched;

    localparam int NR    = 4;
    localparam int DW    = 64;
    localparam int BEATS = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en;
    logic [NR-1:0]     valid;
    logic [NR*DW-1:0]  data;
    logic [NR-1:0]     ready;
    logic              core_valid, core_sop, core_eop;
    logic [DW-1:0]     core_data;
    logic              core_d_valid, core_s_valid, core_size;
    logic [1:0]        res_id;
    logic              busy;
    logic              stats_clr;
`ifdef SR_COMP_SCHED_STATS_EN
    logic [NR*16-1:0]  blk_cnt, cmp_cnt;
`endif

    always #5 clk = ~clk;

    sr_comp_sched #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .BEATS   (BEATS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sched_en_i     (en),
        .req_valid_i    (valid),
        .req_data_i     (data),
        .req_ready_o    (ready),
        .core_valid_o   (core_valid),
        .core_sop_o     (core_sop),
        .core_eop_o     (core_eop),
        .core_data_o    (core_data),
        .core_d_valid_i (core_d_valid),
        .core_s_valid_i (core_s_valid),
        .core_size_i    (core_size),
`ifdef SR_COMP_SCHED_STATS_EN
        .stats_clr_i    (stats_clr),
        .blk_cnt_o      (blk_cnt),
        .cmp_cnt_o      (cmp_cnt),
`endif
        .res_id_o       (res_id),
        .busy_o         (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the core, how many beats it has delivered,
    // where the next round-robin search starts, and what the core should see.
    int          m_owner, m_cnt, m_start, m_s1, m_res;
    logic        m_cv, m_sop, m_eop;
    logic [63:0] m_data;
    logic [3:0]  ready_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_start = 0; m_s1 = 0; m_res = 0;
        m_cv = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_data = '0;
    endtask

    function automatic logic [3:0] model_ready();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic model_edge(input logic e, input logic [3:0] v, input logic [NR*DW-1:0] d);
        logic acc;
        acc = (m_owner >= 0) && v[m_owner];
        if (m_cv) m_res = m_s1;
        m_cv   = acc;
        m_sop  = acc && (m_cnt == 0);
        m_eop  = acc && (m_cnt == BEATS - 1);
        m_data = '0;
        if (acc) begin
            m_data = d[m_owner*DW +: DW];
            m_s1   = m_owner;
        end
        if (m_owner < 0) begin
            if (e && (v != 0)) begin
                for (int k = 0; k < NR; k++) begin
                    int r;
                    r = (m_start + k) % NR;
                    if (m_owner < 0 && v[r]) begin
                        m_owner = r;
                        m_start = (r + 1) % NR;
                    end
                end
            end
        end else if (acc) begin
            m_cnt++;
            if (m_cnt == BEATS) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    // One clock: drive, check ready before the edge, check core side after it
    task automatic step(input logic e, input logic [3:0] v, input logic [NR*DW-1:0] d);
        en = e; valid = v; data = d;
        #1;
        ready_seen = ready;
        check("ready", ready, model_ready());
        model_edge(e, v, d);
        @(posedge clk);
        #1;
        check("core_ctl", {core_valid, core_sop, core_eop, res_id, busy},
              {m_cv, m_sop, m_eop, 2'(m_res), (m_owner >= 0)});
        check("core_data", core_data, m_data);
    endtask

    task automatic apply_reset();
        rst = 1'b1; en = 1'b0; valid = '0; data = '0;
        core_s_valid = 1'b0; core_size = 1'b0; stats_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {ready, core_valid, core_sop, core_eop, res_id, busy}, '0);
        check("reset_data", core_data, '0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [NR*DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NR*DW-1:0] slot_data(input int r, input logic [63:0] val);
        logic [NR*DW-1:0] d;
        d = {NR{64'hbad0_bad0_bad0_bad0}};
        d[r*DW +: DW] = val;
        return d;
    endfunction

    typedef struct {
        logic        en;
        logic [3:0]  v;
        logic [63:0] d0;
        logic [3:0]  e_ready;
        logic        e_cv, e_sop, e_eop;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] order[$];
        int         runs[$];
        int         run_len;
        logic [3:0] prev_ready;
        logic [3:0] exp_order[5];

        core_d_valid = 1'b0;
        model_reset();
        apply_reset();

        // Single req0 block, then bubble, then the next block starts
        tbl[0] = '{1'b1, 4'b0001, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0};
        for (int k = 1; k <= 16; k++) begin
            tbl[k] = '{1'b1, 4'b0001, 64'(k - 1), 4'b0001, 1'b1, (k == 1), (k == 16), 64'(k - 1)};
        end
        tbl[17] = '{1'b1, 4'b0001, 64'h10, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[18] = '{1'b1, 4'b0001, 64'h20, 4'b0001, 1'b1, 1'b1, 1'b0, 64'h20};
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].v, slot_data(0, tbl[i].d0));
            check("tbl_ready", ready_seen, tbl[i].e_ready);
            check("tbl_core", {core_valid, core_sop, core_eop},
                  {tbl[i].e_cv, tbl[i].e_sop, tbl[i].e_eop});
            check("tbl_data", core_data, tbl[i].e_data);
        end

        // All requesters valid: grant order 0,1,2,3,0 with 16-beat holds
        apply_reset();
        prev_ready = '0;
        run_len    = 0;
        for (int i = 0; i < 86; i++) begin
            step(1'b1, 4'b1111, rnd_data());
            if (ready_seen != 0 && prev_ready == 0) order.push_back(ready_seen);
            if (ready_seen != 0) run_len++;
            else if (run_len != 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            prev_ready = ready_seen;
        end
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("grant_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("grant_order", order[i], exp_order[i]);
        check("run_count", 64'(runs.size()), 64'd5);
        foreach (runs[i]) check("hold_len", 64'(runs[i]), 64'(BEATS));

        // Req1 pauses for 3 cycles after 5 beats; req3 must not be granted meanwhile
        apply_reset();
        step(1'b1, 4'b1010, slot_data(1, 64'hff));
        for (int b = 0; b < 5; b++) step(1'b1, 4'b1010, slot_data(1, 64'(b)));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1000, slot_data(1, 64'hee));
            check("drop_ready", ready_seen, 4'b0010);
            check("drop_stall", core_valid, 1'b0);
        end
        for (int b = 5; b < 16; b++) begin
            step(1'b1, 4'b1010, slot_data(1, 64'(b)));
            if (b == 5) check("resume_beat", {core_valid, core_sop, core_data}, {2'b10, 64'd5});
            if (b == 15) check("drop_eop", {core_valid, core_eop}, 2'b11);
        end
        step(1'b1, 4'b1010, rnd_data());
        check("drop_bubble", ready_seen, 4'b0000);
        step(1'b1, 4'b1010, rnd_data());
        check("drop_next", ready_seen, 4'b1000);

        // sched_en drops at beat 8: block completes, then no new grant until re-enabled
        apply_reset();
        step(1'b1, 4'b0001, rnd_data());
        for (int b = 0; b < 8; b++) step(1'b1, 4'b0001, rnd_data());
        for (int b = 8; b < 16; b++) step(1'b0, 4'b0001, rnd_data());
        check("en_low_eop", {core_valid, core_eop}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0001, rnd_data());
            check("en_low_idle", {ready_seen, busy}, 5'b0);
        end
        step(1'b1, 4'b0001, rnd_data());
        check("en_rearm", ready_seen, 4'b0000);
        step(1'b1, 4'b0001, rnd_data());
        check("en_regrant", ready_seen, 4'b0001);

        // Result tagging for req2 and mock core size reply
        apply_reset();
        stats_clr = 1'b1;
        step(1'b1, 4'b0000, '0);
        stats_clr = 1'b0;
        step(1'b1, 4'b0100, rnd_data());
        for (int b = 0; b < 16; b++) step(1'b1, 4'b0100, rnd_data());
        for (int i = 0; i < 2; i++) step(1'b1, 4'b0000, rnd_data());
        check("res_id_req2", res_id, 2'd2);
        core_s_valid = 1'b1;
        core_size    = 1'b0;
        step(1'b1, 4'b0000, rnd_data());
        core_s_valid = 1'b0;
`ifdef SR_COMP_SCHED_STATS_EN
        check("blk_cnt2", blk_cnt[2*16 +: 16], 16'd1);
        check("cmp_cnt2", cmp_cnt[2*16 +: 16], 16'd1);
        check("blk_cnt0", blk_cnt[0 +: 16], 16'd0);
        stats_clr = 1'b1;
        step(1'b1, 4'b0000, rnd_data());
        stats_clr = 1'b0;
        check("stats_clr", {blk_cnt[2*16 +: 16], cmp_cnt[2*16 +: 16]}, 32'd0);
`endif

        // Asynchronous reset at beat 7, then the next grant restarts at req0
        apply_reset();
        step(1'b1, 4'b0100, rnd_data());
        for (int b = 0; b < 7; b++) step(1'b1, 4'b0100, rnd_data());
        rst = 1'b1;
        #1;
        check("rst_async", {ready, core_valid, core_sop, core_eop, res_id, busy, core_data}, '0);
        @(posedge clk);
        #1;
        check("rst_edge", {ready, core_valid, core_sop, core_eop, res_id, busy, core_data}, '0);
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'b1111, rnd_data());
        check("rst_idle", ready_seen, 4'b0000);
        step(1'b1, 4'b1111, rnd_data());
        check("rst_regrant", ready_seen, 4'b0001);

        // Random traffic against the model
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] v;
            for (int r = 0; r < NR; r++) v[r] = ($urandom_range(9) < 7);
            step(($urandom_range(7) != 0), v, rnd_data());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
